// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store unit sitting between the memory stage of the data
//               path and a 4 x 8-bit big-endian, word-addressed data memory.
//               Supports lb/lbu/lh/lhu/lw/sb/sh/sw.  The memory has a single
//               write enable and no byte enables, so sub-word stores are done
//               as read-modify-write.  The fixed memory read latency is hidden
//               behind one req/resp handshake; the data path stalls on busy.
// Ports       : clk_i / rst_b_i        clock, async active-high reset
//               req_*                  request (accepted on valid & ready)
//               resp_*                 one-cycle completion pulse + data/error
//               busy_o                 inverse of req_ready_o
//               mem_addr_o             word address (low two bits zero)
//               mem_data_in_o[0:3]     write lanes, lane 0 = MSB
//               mem_data_out_i[0:3]    read lanes, lane 0 = MSB
//               mem_write_en_o         one-cycle write strobe per store
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_b_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_write_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_signed_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic            resp_err_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            busy_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [7:0]      mem_data_in_o  [0:3],
    input  logic [7:0]      mem_data_out_i [0:3],
    output logic            mem_write_en_o
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;      // only sub-word stores need it later
    logic [CNT_W-1:0]  lat_cnt_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [7:0]        mem_data_in_q [0:3];
    logic              mem_we_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;

    logic              req_err_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       word_sel;
    logic [XLEN-1:0]   rdata_d;
    logic [7:0]        merge_d [0:3];

    // Misaligned halfword/word or reserved size: answered without touching memory.
    always_comb begin
        req_err_d = 1'b0;
        case (req_size_i)
            2'd1:    req_err_d = req_addr_i[0];
            2'd2:    req_err_d = (req_addr_i[1:0] != 2'b00);
            2'd3:    req_err_d = 1'b1;
            default: req_err_d = 1'b0;
        endcase
    end

    // Load lane selection and extension from the word currently on the bus.
    always_comb begin
        byte_sel = mem_data_out_i[off_q];
        half_sel = {mem_data_out_i[off_q], mem_data_out_i[off_q + 2'd1]};
        word_sel = {mem_data_out_i[0], mem_data_out_i[1],
                    mem_data_out_i[2], mem_data_out_i[3]};
        case (size_q)
            2'd0:    rdata_d = signed_q ? XLEN'($signed(byte_sel)) : XLEN'(byte_sel);
            2'd1:    rdata_d = signed_q ? XLEN'($signed(half_sel)) : XLEN'(half_sel);
            default: rdata_d = XLEN'(word_sel);
        endcase
    end

    // Read-modify-write merge: replace only the addressed lanes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merge_d[i] = mem_data_out_i[i];
        end
        if (size_q == 2'd0) begin
            merge_d[off_q] = wdata_q[7:0];
        end else begin
            merge_d[off_q]        = wdata_q[15:8];
            merge_d[off_q + 2'd1] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_b_i) begin
        if (rst_b_i) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            off_q        <= 2'd0;
            wdata_q      <= '0;
            lat_cnt_q    <= '0;
            mem_addr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_data_in_q[i] <= '0;
            end
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        size_q   <= req_size_i;
                        signed_q <= req_signed_i;
                        off_q    <= req_addr_i[1:0];
                        wdata_q  <= req_wdata_i[15:0];
                        if (req_err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else begin
                            mem_addr_q <= {req_addr_i[XLEN-1:2], 2'b00};
                            lat_cnt_q  <= CNT_W'(MEM_LATENCY - 1);
                            if (req_write_i && (req_size_i == 2'd2)) begin
                                // Full-word store needs no read.
                                mem_data_in_q[0] <= req_wdata_i[31:24];
                                mem_data_in_q[1] <= req_wdata_i[23:16];
                                mem_data_in_q[2] <= req_wdata_i[15:8];
                                mem_data_in_q[3] <= req_wdata_i[7:0];
                                mem_we_q         <= 1'b1;
                                state_q          <= WR;
                            end else begin
                                state_q <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        if (write_q) begin
                            mem_data_in_q <= merge_d;
                            mem_we_q      <= 1'b1;
                            state_q       <= WR;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= rdata_d;
                            state_q      <= RESP;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                WR: begin
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign resp_valid_o   = resp_valid_q;
    assign resp_err_o     = resp_err_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_in_o  = mem_data_in_q;
    assign mem_write_en_o = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Self-checking bench for lsu_mem_ctrl.  Two instances share the
//               request bus (latency 1 and latency 3), each with its own
//               behavioural memory; 'sel' picks the active one.  Expected
//               responses and writes are queued at acceptance and compared
//               when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        w = 1'b0;
    logic [1:0]  sz = 2'd0;
    logic        sg = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;

    logic        rdy1, rdy3, rv1, rv3, re1, re3, bsy1, bsy3, we1, we3;
    logic [31:0] rd1, rd3, addr1, addr3;
    logic [7:0]  din1 [0:3];
    logic [7:0]  din3 [0:3];
    logic [7:0]  dout1 [0:3];
    logic [7:0]  dout3 [0:3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    resp_t rq[$];
    wr_t   wq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_ctrl #(.XLEN(32), .MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_b_i(rst),
        .req_valid_i(valid & ~sel), .req_ready_o(rdy1),
        .req_write_i(w), .req_size_i(sz), .req_signed_i(sg),
        .req_addr_i(a), .req_wdata_i(wd),
        .resp_valid_o(rv1), .resp_err_o(re1), .resp_rdata_o(rd1),
        .busy_o(bsy1), .mem_addr_o(addr1),
        .mem_data_in_o(din1), .mem_data_out_i(dout1), .mem_write_en_o(we1)
    );

    lsu_mem_ctrl #(.XLEN(32), .MEM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_b_i(rst),
        .req_valid_i(valid & sel), .req_ready_o(rdy3),
        .req_write_i(w), .req_size_i(sz), .req_signed_i(sg),
        .req_addr_i(a), .req_wdata_i(wd),
        .resp_valid_o(rv3), .resp_err_o(re3), .resp_rdata_o(rd3),
        .busy_o(bsy3), .mem_addr_o(addr3),
        .mem_data_in_o(din3), .mem_data_out_i(dout3), .mem_write_en_o(we3)
    );

    // Behavioural memories: data is only presented once the address has been
    // stable for the instance's latency, otherwise a poison pattern.
    logic [31:0] mem1 [0:15];
    logic [31:0] mem3 [0:15];
    logic [31:0] prev1 = '0;
    logic [31:0] prev3 = '0;
    int          cnt1 = 0;
    int          cnt3 = 0;
    int          held1, held3;
    logic [31:0] rw1, rw3;

    always @(posedge clk) begin
        if (we1) mem1[addr1[5:2]] <= {din1[0], din1[1], din1[2], din1[3]};
        if (we3) mem3[addr3[5:2]] <= {din3[0], din3[1], din3[2], din3[3]};
        cnt1  <= (addr1 == prev1) ? cnt1 + 1 : 1;
        cnt3  <= (addr3 == prev3) ? cnt3 + 1 : 1;
        prev1 <= addr1;
        prev3 <= addr3;
    end

    always_comb begin
        held1 = (addr1 == prev1) ? cnt1 + 1 : 1;
        held3 = (addr3 == prev3) ? cnt3 + 1 : 1;
        rw1   = (held1 >= 1) ? mem1[addr1[5:2]] : 32'hDEAD_BEEF;
        rw3   = (held3 >= 3) ? mem3[addr3[5:2]] : 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            dout1[i] = rw1[31-8*i -: 8];
            dout3[i] = rw3[31-8*i -: 8];
        end
    end

    // Observation mux onto the selected instance.
    wire        o_ready = sel ? rdy3 : rdy1;
    wire        o_rv    = sel ? rv3  : rv1;
    wire        o_err   = sel ? re3  : re1;
    wire        o_busy  = sel ? bsy3 : bsy1;
    wire        o_we    = sel ? we3  : we1;
    wire [31:0] o_rdata = sel ? rd3  : rd1;
    wire [31:0] o_maddr = sel ? addr3 : addr1;
    wire [31:0] o_din   = sel ? {din3[0], din3[1], din3[2], din3[3]}
                              : {din1[0], din1[1], din1[2], din1[3]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare every response and write as it appears.
    always @(negedge clk) begin
        resp_t r;
        wr_t   x;
        if (o_rv) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                chk("resp_err", 32'(o_err), 32'(r.err));
                if (r.chk_rd) chk("resp_rdata", o_rdata, r.rdata);
            end
        end
        if (o_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                x = wq.pop_front();
                chk("write_cycle", 32'(cyc), 32'(x.cyc));
                chk("write_addr", o_maddr, x.addr);
                chk("write_data", o_din, x.data);
            end
        end
    end

    // Drive one request (called at a negedge) and queue its expectations.
    task automatic issue(input logic wr, input logic [1:0] s, input logic sgn,
                         input logic [31:0] ad, input logic [31:0] wdt,
                         input logic e_err, input logic [31:0] e_rd,
                         input logic [31:0] e_mem, output int t);
        int lat;
        int guard;
        lat   = sel ? 3 : 1;
        valid = 1'b1;
        w     = wr;
        sz    = s;
        sg    = sgn;
        a     = ad;
        wd    = wdt;
        guard = 0;
        while (!o_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        t = cyc;
        if (!o_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            valid = 1'b0;
            return;
        end
        if (e_err) begin
            rq.push_back('{t + 1, 1'b1, 32'h0, 1'b1});
        end else if (wr && s == 2'd2) begin
            wq.push_back('{t + 1, {ad[31:2], 2'b00}, e_mem});
            rq.push_back('{t + 2, 1'b0, 32'h0, 1'b0});
        end else if (wr) begin
            wq.push_back('{t + lat + 1, {ad[31:2], 2'b00}, e_mem});
            rq.push_back('{t + lat + 2, 1'b0, 32'h0, 1'b0});
        end else begin
            rq.push_back('{t + lat + 1, 1'b0, e_rd, 1'b1});
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rq.size() != 0 || wq.size() != 0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            chk("drain_timeout", 32'(rq.size() + wq.size()), 32'd0);
            rq.delete();
            wq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_resp_valid", 32'(o_rv), 32'd0);
        chk("rst_resp_err", 32'(o_err), 32'd0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_mem_addr", o_maddr, 32'h0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_din", o_din, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // sw timing and lane order (latency 1)
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 32'h1122_3344, t1);
        drain();

        // Loads of all sizes and signedness
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hA1B2_C3D4, 1'b0, 32'h0, 32'hA1B2_C3D4, t1);
        drain();
        issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b0, 32'hFFFF_FFD4, 32'h0, t1); drain();
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0000_00B2, 32'h0, t1); drain();
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFF_A1B2, 32'h0, t1); drain();
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, 32'h0000_C3D4, 32'h0, t1); drain();
        repeat (3) @(negedge clk);
        chk("rdata_hold", o_rdata, 32'h0000_C3D4);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA1B2_C3D4, 32'h0, t1); drain();

        // Read-modify-write stores
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0055, 1'b0, 32'h0, 32'hA155_C3D4, t1); drain();
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_9988, 1'b0, 32'h0, 32'hA155_9988, t1); drain();
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA155_9988, 32'h0, t1); drain();

        // Misaligned / reserved accesses
        issue(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 32'h0, t1); drain();
        issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0, 32'h0, t1); drain();
        issue(1'b1, 2'd3, 1'b0, 32'h24, 32'h0, 1'b1, 32'h0, 32'h0, t1); drain();
        chk("err_mem_addr", o_maddr, 32'h20);

        // Latency 3 instance
        sel = 1'b1;
        @(negedge clk);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hA155_9988, 1'b0, 32'h0, 32'hA155_9988, t1); drain();
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA155_9988, 32'h0, t1);
        // Request held high while busy: must be taken only after the response.
        issue(1'b1, 2'd0, 1'b0, 32'h23, 32'h0000_0077, 1'b0, 32'h0, 32'hA155_9977, t2);
        chk("held_accept_cycle", 32'(t2), 32'(t1 + 5));
        drain();
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA155_9977, 32'h0, t1); drain();

        // Reset during RD_WAIT of a byte store aborts it
        issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_0000, 1'b0, 32'h0, 32'h0, t1);
        rst = 1'b1;
        #1;
        rq.delete();
        wq.delete();
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_resp_valid", 32'(o_rv), 32'd0);
        chk("abort_rdata", o_rdata, 32'h0);
        chk("abort_mem_addr", o_maddr, 32'h0);
        chk("abort_we", 32'(o_we), 32'd0);
        chk("abort_din", o_din, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA155_9977, 32'h0, t1); drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
